// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the MUSA core: PC, instruction-memory req/ack, valid/ready output to decode,
// and redirect handling (jump, relative branch, call/return through a circular return-address stack).
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RAS_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [5:0]            opcode,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  write_pc,
  input  logic [1:0]            branch,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic                  push,
  input  logic                  halt,
  output logic                  halted,
  output logic                  ras_err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    req_q, req_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic                    halted_q, halted_d;
  logic                    err_q, err_d;
  logic [PW-1:0]           sp_q, sp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   ras_q [RAS_DEPTH];

  logic                    ras_we_s;
  logic [PW-1:0]           ras_widx_s;
  logic [ADDR_WIDTH-1:0]   ras_wdata_s;
  logic [ADDR_WIDTH-1:0]   ras_top_s;
  logic                    pop_s;
  logic                    pop_ok_s;
  logic [PW-1:0]           sp_pop_s;
  logic [CW-1:0]           cnt_pop_s;
  logic [ADDR_WIDTH-1:0]   next_pc_s;
  logic                    accept_s;

  assign accept_s  = valid_q & instr_ready;
  assign pop_ok_s  = (cnt_q != {CW{1'b0}});
  assign ras_top_s = ras_q[sp_q - PW'(1)];

  // Redirect target selection; pc_q already holds the incremented (return) address here.
  always_comb begin
    next_pc_s = pc_q;
    pop_s     = 1'b0;
    if (write_pc) begin
      case (branch)
        2'b01:   next_pc_s = target;
        2'b10:   next_pc_s = pc_q + target;
        2'b11: begin
          pop_s     = 1'b1;
          next_pc_s = pop_ok_s ? ras_top_s : RESET_PC;
        end
        default: next_pc_s = pc_q;
      endcase
    end else begin
      next_pc_s = pc_q;
    end
  end

  // Stack position after an optional pop, so a same-cycle push replaces the popped top.
  always_comb begin
    sp_pop_s  = sp_q;
    cnt_pop_s = cnt_q;
    if (pop_s && pop_ok_s) begin
      sp_pop_s  = sp_q - PW'(1);
      cnt_pop_s = cnt_q - CW'(1);
    end else begin
      sp_pop_s  = sp_q;
      cnt_pop_s = cnt_q;
    end
  end

  // Fetch FSM next-state and output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    err_d       = err_q;
    sp_d        = sp_q;
    cnt_d       = cnt_q;
    ras_we_s    = 1'b0;
    ras_widx_s  = sp_pop_s;
    ras_wdata_s = pc_q;
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          req_d   = 1'b0;
          state_d = S_HOLD;
        end else begin
          req_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (accept_s) begin
          valid_d = 1'b0;
          if (halt) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            state_d = S_FETCH;
            pc_d    = next_pc_s;
            req_d   = 1'b1;
            addr_d  = next_pc_s;
            sp_d    = sp_pop_s;
            cnt_d   = cnt_pop_s;
            if (pop_s && !pop_ok_s) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            // A push on a full stack wraps over the oldest entry; depth stays saturated.
            if (push) begin
              ras_we_s = 1'b1;
              sp_d     = sp_pop_s + PW'(1);
              if (cnt_pop_s == CW'(RAS_DEPTH)) begin
                err_d = 1'b1;
              end else begin
                cnt_d = cnt_pop_s + CW'(1);
              end
            end else begin
              ras_we_s = 1'b0;
            end
          end
        end else begin
          valid_d = valid_q;
        end
      end
      S_HALT: begin
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      instr_q  <= {DATA_WIDTH{1'b0}};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      sp_q     <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
    end
  end

  // Return-address stack storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= RESET_PC;
      end
    end else if (ras_we_s) begin
      ras_q[ras_widx_s] <= ras_wdata_s;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[DATA_WIDTH-1 -: 6];
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign ras_err     = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized self-checking bench for instruction_fetch_unit; expected PCs and return addresses
// come from a queue-based reference model of the fetch/redirect rules.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        write_pc = 1'b0;
  logic [1:0]  branch = 2'b00;
  logic [15:0] target = 16'h0;
  logic        push = 1'b0;
  logic        halt = 1'b0;
  logic        halted;
  logic        ras_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [31:0] m_instr;
  logic        m_err;
  logic        m_halted;
  logic [15:0] m_ras[$];
  logic [15:0] rets [9];

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .write_pc(write_pc),
    .branch(branch), .target(target), .push(push), .halt(halt),
    .halted(halted), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; write_pc = 1'b0; push = 1'b0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, imem_addr, instr, instr_valid, halted, ras_err} !== {1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got req=%b addr=%h instr=%h v=%b h=%b e=%b exp all zero",
               imem_req, imem_addr, instr, instr_valid, halted, ras_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_pc = 16'h0; m_err = 1'b0; m_halted = 1'b0; m_ras.delete();
  endtask

  task automatic fetch_one(input int lat);
    int n = 0;
    logic [15:0] a;
    logic [31:0] d;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL req_timeout got req=%b exp 1", imem_req);
    end
    checks++;
    if (imem_addr !== m_pc) begin
      errors++; $display("FAIL fetch_addr got %h exp %h", imem_addr, m_pc);
    end
    a = imem_addr;
    repeat (lat) begin
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_stable got req=%b addr=%h v=%b exp 1 %h 0", imem_req, imem_addr, instr_valid, a);
      end
    end
    d = $urandom;
    imem_rdata = d; imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = $urandom;
    checks++;
    if (instr_valid !== 1'b1 || instr !== d || opcode !== d[31:26] || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_data got v=%b instr=%h op=%h req=%b exp 1 %h %h 0",
               instr_valid, instr, opcode, imem_req, d, d[31:26]);
    end
    m_instr = d;
    m_pc = m_pc + 16'h1;
  endtask

  task automatic accept(input int dly, input logic wp, input logic [1:0] br,
                        input logic [15:0] tgt, input logic ps, input logic hl);
    logic [15:0] nxt;
    repeat (dly) begin
      imem_ack = 1'($urandom_range(0, 1));
      write_pc = 1'($urandom_range(0, 1)); branch = 2'($urandom_range(0, 3));
      push = 1'($urandom_range(0, 1)); halt = 1'($urandom_range(0, 1)); target = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (instr_valid !== 1'b1 || instr !== m_instr || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable got v=%b instr=%h req=%b exp 1 %h 0", instr_valid, instr, imem_req, m_instr);
      end
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1; write_pc = wp; branch = br; target = tgt; push = ps; halt = hl;
    @(posedge clk); #1;
    instr_ready = 1'b0; write_pc = 1'b0; branch = 2'b00; push = 1'b0; halt = 1'b0;
    if (hl) begin
      m_halted = 1'b1;
    end else begin
      nxt = m_pc;
      if (wp && br == 2'b01) nxt = tgt;
      if (wp && br == 2'b10) nxt = m_pc + tgt;
      if (wp && br == 2'b11) begin
        if (m_ras.size() > 0) nxt = m_ras.pop_back();
        else begin nxt = 16'h0; m_err = 1'b1; end
      end
      if (ps) begin
        if (m_ras.size() == 8) begin void'(m_ras.pop_front()); m_err = 1'b1; end
        m_ras.push_back(m_pc);
      end
      m_pc = nxt;
    end
    checks++;
    if (instr_valid !== 1'b0 || ras_err !== m_err || halted !== m_halted) begin
      errors++;
      $display("FAIL accept_state got v=%b err=%b halted=%b exp 0 %b %b", instr_valid, ras_err, halted, m_err, m_halted);
    end
  endtask

  task automatic test_latency();
    fetch_one(0); accept(0, 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    fetch_one(3); accept(1, 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    fetch_one(0);
    checks++;
    if (instr_valid !== 1'b1 || m_pc !== 16'h0003) begin
      errors++; $display("FAIL latency_seq got v=%b pc=%h exp 1 0003", instr_valid, m_pc);
    end
  endtask

  task automatic test_hold();
    accept(5, 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    fetch_one(1);
    accept(0, 1'b1, 2'b01, 16'h0040, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 16'h0040) begin errors++; $display("FAIL jump_abs got %h exp 0040", imem_addr); end
    fetch_one(0);
    accept(0, 1'b1, 2'b01, 16'h0005, 1'b0, 1'b0);
    fetch_one(2);
    accept(1, 1'b1, 2'b10, 16'hFFFE, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 16'h0004) begin errors++; $display("FAIL jump_rel got %h exp 0004", imem_addr); end
  endtask

  task automatic test_call();
    fetch_one(0);
    accept(0, 1'b1, 2'b01, 16'h0010, 1'b0, 1'b0);
    fetch_one(0);
    accept(0, 1'b1, 2'b01, 16'h0080, 1'b1, 1'b0);
    checks++;
    if (imem_addr !== 16'h0080) begin errors++; $display("FAIL call_addr got %h exp 0080", imem_addr); end
    fetch_one(1);
    accept(0, 1'b1, 2'b11, 16'h0, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 16'h0011 || ras_err !== 1'b0) begin
      errors++; $display("FAIL ret_addr got %h err=%b exp 0011 0", imem_addr, ras_err);
    end
  endtask

  task automatic test_empty_return();
    test_reset();
    fetch_one(0);
    accept(0, 1'b1, 2'b01, 16'h0123, 1'b0, 1'b0);
    fetch_one(0);
    accept(0, 1'b1, 2'b11, 16'h0, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 16'h0000 || ras_err !== 1'b1) begin
      errors++; $display("FAIL empty_ret got %h err=%b exp 0000 1", imem_addr, ras_err);
    end
    fetch_one(2);
    accept(0, 1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
    checks++;
    if (ras_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", ras_err); end
  endtask

  task automatic test_nested();
    test_reset();
    for (int i = 0; i < 9; i++) begin
      fetch_one(i % 3);
      rets[i] = m_pc;
      accept(0, 1'b1, 2'b01, 16'h0200 + 16'(i * 16), 1'b1, 1'b0);
    end
    checks++;
    if (ras_err !== 1'b1) begin errors++; $display("FAIL overflow_err got %b exp 1", ras_err); end
    for (int k = 0; k < 8; k++) begin
      fetch_one(0);
      accept(0, 1'b1, 2'b11, 16'h0, 1'b0, 1'b0);
      checks++;
      if (imem_addr !== rets[8 - k]) begin
        errors++; $display("FAIL nested_ret%0d got %h exp %h", k, imem_addr, rets[8 - k]);
      end
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 60; i++) begin
      fetch_one($urandom_range(0, 3));
      accept($urandom_range(0, 3), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             16'($urandom), ($urandom_range(0, 2) == 0), 1'b0);
    end
  endtask

  task automatic test_halt();
    fetch_one(1);
    accept(2, 1'b1, 2'b01, 16'h0777, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL halt_state got h=%b req=%b v=%b exp 1 0 0", halted, imem_req, instr_valid);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    test_reset();
    fetch_one(0);
    accept(0, 1'b1, 2'b11, 16'h0, 1'b0, 1'b0);
    fetch_one(0);
    accept(0, 1'b1, 2'b01, 16'h0033, 1'b0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0033 || ras_err !== 1'b1) begin
      errors++; $display("FAIL pre_reset got req=%b addr=%h err=%b exp 1 0033 1", imem_req, imem_addr, ras_err);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, instr, instr_valid, halted, ras_err} !== {1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got req=%b addr=%h instr=%h v=%b h=%b e=%b exp all zero",
               imem_req, imem_addr, instr, instr_valid, halted, ras_err);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold();
    test_branch();
    test_call();
    test_empty_return();
    test_nested();
    test_random();
    test_halt();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
